// File: rtl/rr_onehot_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_onehot_arb_mux
// Description : Round-robin arbiter with a one-hot grant. It muxes 2**s
//               valid/ready channels into a single-entry registered output
//               stage. Optional macro ARB_LOCK_EN adds a per-channel grant
//               lock.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_onehot_arb_mux #(
  parameter int s     = 2,
  parameter int width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [(1<<s)-1:0]     req_valid,
  input  logic [width-1:0]      req_data [1<<s],
  input  logic [(1<<s)-1:0]     req_lock,
  output logic [(1<<s)-1:0]     req_ready,
  output logic                  out_valid,
  output logic [width-1:0]      out_data,
  output logic [(1<<s)-1:0]     out_grant,
  input  logic                  out_ready
);

  localparam int N = 1 << s;

  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_data_q,  out_data_d;
  logic [N-1:0]     out_grant_q, out_grant_d;
  logic [s-1:0]     ptr_q,       ptr_d;

  logic             w_load_en;
  logic             w_accept;
  logic [N-1:0]     w_rr_grant;
  logic [s-1:0]     w_rr_idx;
  logic             w_rr_found;
  logic [s-1:0]     w_scan;
  logic [N-1:0]     w_grant;
  logic [s-1:0]     w_sel;

  assign w_load_en = !out_valid_q | out_ready;

  // First valid channel scanning upward from ptr; s-bit index wraps naturally.
  always_comb begin
    w_rr_grant = '0;
    w_rr_idx   = '0;
    w_rr_found = 1'b0;
    w_scan     = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = ptr_q + k[s-1:0];
      if (!w_rr_found && req_valid[w_scan]) begin
        w_rr_found         = 1'b1;
        w_rr_idx           = w_scan;
        w_rr_grant[w_scan] = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic         lock_q,     lock_d;
  logic [s-1:0] lock_idx_q, lock_idx_d;

  // A locked channel excludes everyone else, even while it is idle.
  always_comb begin
    w_grant = w_rr_grant;
    w_sel   = w_rr_idx;
    if (lock_q) begin
      w_sel   = lock_idx_q;
      w_grant = '0;
      w_grant[lock_idx_q] = req_valid[lock_idx_q];
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (w_accept) begin
      lock_d     = req_lock[w_sel];
      lock_idx_d = w_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign w_grant     = w_rr_grant;
  assign w_sel       = w_rr_idx;
`endif

  assign req_ready = rst ? '0 : (w_grant & {N{w_load_en}});
  assign w_accept  = |(req_valid & req_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grant_d = out_grant_q;
    ptr_d       = ptr_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[w_sel];
      out_grant_d = w_grant;
`ifdef ARB_LOCK_EN
      if (!req_lock[w_sel]) ptr_d = w_sel + 1'b1;
`else
      ptr_d = w_sel + 1'b1;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grant_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grant_q <= out_grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_grant = out_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_onehot_arb_mux
// Description : Directed self-checking bench for rr_onehot_arb_mux (s=2,
//               width=8). Lock expectations follow ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_onehot_arb_mux;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data [4];
  logic [3:0] req_lock;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_grant;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  rr_onehot_arb_mux #(.s(2), .width(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    req_data[0] = d0; req_data[1] = d1; req_data[2] = d2; req_data[3] = d3;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = 4'b0000; req_lock = 4'b0000; out_ready = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'b1111; req_lock = 4'b0000; out_ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    tick;
    tick;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant: got %b want 0000", out_grant); end
    n_checks++; if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    rst = 1'b0; req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d [5];
    logic [3:0] exp_g [5];
    exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12; exp_d[3] = 8'h13; exp_d[4] = 8'h10;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    req_valid = 4'b1111; out_ready = 1'b1;
    settle;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rr_first_ready: got %b want 0001", req_ready); end
    for (int b = 0; b < 5; b++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL rr_valid beat%0d: got %b want 1", b, out_valid); end
      n_checks++; if (out_data !== exp_d[b]) begin n_errors++; $display("FAIL rr_data beat%0d: got %h want %h", b, out_data, exp_d[b]); end
      n_checks++; if (out_grant !== exp_g[b]) begin n_errors++; $display("FAIL rr_grant beat%0d: got %b want %b", b, out_grant, exp_g[b]); end
    end
  endtask

  // Continues from test_round_robin: last accept was ch0, so ptr=1.
  task automatic test_idle_drain;
    req_valid = 4'b0000;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h10) begin n_errors++; $display("FAIL drain_data_hold: got %h want 10", out_data); end
    n_checks++; if (out_grant !== 4'b0001) begin n_errors++; $display("FAIL drain_grant_hold: got %b want 0001", out_grant); end
    tick;
    req_valid = 4'b1111;
    settle;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL idle_ptr_ready: got %b want 0010", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h11) begin n_errors++; $display("FAIL idle_ptr_data: got %h want 11", out_data); end
    req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_single;
    do_reset;
    out_ready = 1'b1;
    set_data(8'h20, 8'h00, 8'hA5, 8'h23);
    req_valid = 4'b0100;
    settle;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", out_data); end
    n_checks++; if (out_grant !== 4'b0100) begin n_errors++; $display("FAIL single_grant: got %b want 0100", out_grant); end
    req_valid = 4'b1001;
    settle;
    n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL pair_ready_ch3: got %b want 1000", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h23) begin n_errors++; $display("FAIL pair_data_ch3: got %h want 23", out_data); end
    n_checks++; if (out_grant !== 4'b1000) begin n_errors++; $display("FAIL pair_grant_ch3: got %b want 1000", out_grant); end
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL pair_ready_ch0: got %b want 0001", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h20) begin n_errors++; $display("FAIL pair_data_ch0: got %h want 20", out_data); end
    n_checks++; if (out_grant !== 4'b0001) begin n_errors++; $display("FAIL pair_grant_ch0: got %b want 0001", out_grant); end
    req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    out_ready = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    req_valid = 4'b0010;
    tick;
    n_checks++; if (out_data !== 8'h11) begin n_errors++; $display("FAIL bp_load: got %h want 11", out_data); end
    out_ready = 1'b0; req_valid = 4'b1111;
    settle;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid cyc%0d: got %b want 1", c, out_valid); end
      n_checks++; if (out_data !== 8'h11) begin n_errors++; $display("FAIL bp_data cyc%0d: got %h want 11", c, out_data); end
      n_checks++; if (out_grant !== 4'b0010) begin n_errors++; $display("FAIL bp_grant cyc%0d: got %b want 0010", c, out_grant); end
      n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready cyc%0d: got %b want 0000", c, req_ready); end
    end
    out_ready = 1'b1;
    settle;
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h12) begin n_errors++; $display("FAIL bp_release_data: got %h want 12", out_data); end
    n_checks++; if (out_grant !== 4'b0100) begin n_errors++; $display("FAIL bp_release_grant: got %b want 0100", out_grant); end
  endtask

  // Continues from test_backpressure: beat 0x12 held, ptr=3.
  task automatic test_reset_mid;
    out_ready = 1'b0;
    rst = 1'b1;
    settle;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL midrst_ready: got %b want 0000", req_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_grant !== 4'b0000) begin n_errors++; $display("FAIL midrst_grant: got %b want 0000", out_grant); end
    rst = 1'b0; out_ready = 1'b1;
    settle;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr_ready: got %b want 0001", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h10) begin n_errors++; $display("FAIL midrst_ptr_data: got %h want 10", out_data); end
    n_checks++; if (out_grant !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr_grant: got %b want 0001", out_grant); end
    req_valid = 4'b0000;
    tick;
  endtask

  task automatic test_lock;
    do_reset;
    out_ready = 1'b1;
    set_data(8'h30, 8'h00, 8'h00, 8'h00);
    req_valid = 4'b0001;
    tick;
    n_checks++; if (out_data !== 8'h30) begin n_errors++; $display("FAIL lock_pre_data: got %h want 30", out_data); end
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    req_valid = 4'b0111; req_lock = 4'b0010;
    settle;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL lock_first_ready: got %b want 0010", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h11) begin n_errors++; $display("FAIL lock_beat0_data: got %h want 11", out_data); end
    n_checks++; if (out_grant !== 4'b0010) begin n_errors++; $display("FAIL lock_beat0_grant: got %b want 0010", out_grant); end
`ifdef ARB_LOCK_EN
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL lock_held_ready: got %b want 0010", req_ready); end
    req_data[1] = 8'h21;
    tick;
    n_checks++; if (out_data !== 8'h21) begin n_errors++; $display("FAIL lock_beat1_data: got %h want 21", out_data); end
    n_checks++; if (out_grant !== 4'b0010) begin n_errors++; $display("FAIL lock_beat1_grant: got %b want 0010", out_grant); end
    req_valid = 4'b0101;
    settle;
    n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL lock_idle_ready: got %b want 0000", req_ready); end
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL lock_idle_valid: got %b want 0", out_valid); end
    req_valid = 4'b0111; req_lock = 4'b0000; req_data[1] = 8'h31;
    settle;
    n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL lock_last_ready: got %b want 0010", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h31) begin n_errors++; $display("FAIL lock_beat2_data: got %h want 31", out_data); end
    n_checks++; if (out_grant !== 4'b0010) begin n_errors++; $display("FAIL lock_beat2_grant: got %b want 0010", out_grant); end
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL lock_release_ready: got %b want 0100", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h12) begin n_errors++; $display("FAIL lock_after_data: got %h want 12", out_data); end
    n_checks++; if (out_grant !== 4'b0100) begin n_errors++; $display("FAIL lock_after_grant: got %b want 0100", out_grant); end
`else
    n_checks++; if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL nolock_ready1: got %b want 0100", req_ready); end
    req_data[1] = 8'h21;
    tick;
    n_checks++; if (out_data !== 8'h12) begin n_errors++; $display("FAIL nolock_beat1_data: got %h want 12", out_data); end
    n_checks++; if (out_grant !== 4'b0100) begin n_errors++; $display("FAIL nolock_beat1_grant: got %b want 0100", out_grant); end
    req_lock = 4'b0000; req_data[1] = 8'h31;
    settle;
    n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL nolock_ready2: got %b want 0001", req_ready); end
    tick;
    n_checks++; if (out_data !== 8'h10) begin n_errors++; $display("FAIL nolock_beat2_data: got %h want 10", out_data); end
    n_checks++; if (out_grant !== 4'b0001) begin n_errors++; $display("FAIL nolock_beat2_grant: got %b want 0001", out_grant); end
    tick;
    n_checks++; if (out_data !== 8'h31) begin n_errors++; $display("FAIL nolock_beat3_data: got %h want 31", out_data); end
    n_checks++; if (out_grant !== 4'b0010) begin n_errors++; $display("FAIL nolock_beat3_grant: got %b want 0010", out_grant); end
`endif
    req_valid = 4'b0000; req_lock = 4'b0000;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 4'b0000; req_lock = 4'b0000; out_ready = 1'b0;
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset;
    test_round_robin;
    test_idle_drain;
    test_single;
    test_backpressure;
    test_reset_mid;
    test_lock;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
